// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator computer control path: opcodes,
// ALU selects, controller states and the micro-operation strobe bundle.
package cpu_pkg;

  localparam int unsigned OP_AND = 0;
  localparam int unsigned OP_ADD = 1;
  localparam int unsigned OP_LDA = 2;
  localparam int unsigned OP_STA = 3;
  localparam int unsigned OP_BUN = 4;
  localparam int unsigned OP_NOP = 5;
  localparam int unsigned OP_RSV = 6;
  localparam int unsigned OP_HLT = 7;

  localparam logic [1:0] ALU_AND  = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_PASS = 2'b10;

  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;

  typedef enum logic [1:0] {
    HALT   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    RESYNC = 2'd3
  } ctrl_state_t;

  typedef struct packed {
    logic       ar_ld_pc;
    logic       ar_ld_ir;
    logic       ar_ld_mem;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld_ar;
    logic       mem_rd;
    logic       mem_wr;
    logic       dr_ld;
    logic       ac_ld;
    logic [1:0] alu_op;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);

endpackage

// File: rtl/uop_decode.sv
// Purely combinational micro-operation decoder: (phase, T, opcode, indirect)
// to the strobe bundle. Gating against the controller state happens upstream.
module uop_decode
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic             phase,
  input  logic [1:0]       t,
  input  logic [OPW-1:0]   ir_op,
  input  logic             ir_i,
  output logic [UOP_W-1:0] uop
);

  uop_t u;

  always_comb begin
    u = '0;
    if (phase == PH_FETCH) begin
      case (t)
        2'd0: u.ar_ld_pc = 1'b1;
        2'd1: begin
          u.mem_rd = 1'b1;
          u.ir_ld  = 1'b1;
          u.pc_inc = 1'b1;
        end
        2'd2: u.ar_ld_ir = 1'b1;
        default: begin
          // Indirect cycle replaces AR with the pointer read from memory
          u.mem_rd    = ir_i;
          u.ar_ld_mem = ir_i;
        end
      endcase
    end else if (t == 2'd0) begin
      case (ir_op)
        OPW'(OP_AND), OPW'(OP_ADD), OPW'(OP_LDA): begin
          u.mem_rd = 1'b1;
          u.dr_ld  = 1'b1;
        end
        OPW'(OP_STA): u.mem_wr   = 1'b1;
        OPW'(OP_BUN): u.pc_ld_ar = 1'b1;
        OPW'(OP_NOP), OPW'(OP_RSV), OPW'(OP_HLT): ;
        default: ;
      endcase
    end else if (t == 2'd1) begin
      case (ir_op)
        OPW'(OP_AND): begin
          u.ac_ld  = 1'b1;
          u.alu_op = ALU_AND;
        end
        OPW'(OP_ADD): begin
          u.ac_ld  = 1'b1;
          u.alu_op = ALU_ADD;
        end
        OPW'(OP_LDA): begin
          u.ac_ld  = 1'b1;
          u.alu_op = ALU_PASS;
        end
        default: ;
      endcase
    end
  end

  assign uop = u;

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle sequencer: drives the sequence counter enable, tracks the
// expected timing state and emits micro-op strobes only while in lock-step.
module instr_cycle_ctrl
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     T,
  input  logic           run,
  input  logic [OPW-1:0] ir_op,
  input  logic           ir_i,
  output logic           sc_e,
  output logic           phase,
  output logic           ar_ld_pc,
  output logic           ar_ld_ir,
  output logic           ar_ld_mem,
  output logic           ir_ld,
  output logic           pc_inc,
  output logic           pc_ld_ar,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           dr_ld,
  output logic           ac_ld,
  output logic [1:0]     alu_op,
  output logic           halted,
  output logic           sync_err
);

  ctrl_state_t state_reg, state_next;
  logic        phase_reg, phase_next;
  logic [1:0]  t_exp_reg, t_exp_next;
  logic        sync_err_reg, sync_err_next;

  logic             t_match;
  logic             hlt_dec;
  logic [UOP_W-1:0] uop_bits;
  uop_t             uop_dec;
  uop_t             uop_out;

  assign t_match = (T == t_exp_reg);
  assign hlt_dec = (phase_reg == PH_EXEC) && (t_exp_reg == 2'd0) &&
                   (ir_op == OPW'(OP_HLT));

  uop_decode #(
    .OPW(OPW)
  ) u_decode (
    .phase(phase_reg),
    .t    (T),
    .ir_op(ir_op),
    .ir_i (ir_i),
    .uop  (uop_bits)
  );

  assign uop_dec = uop_t'(uop_bits);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= HALT;
      phase_reg    <= PH_FETCH;
      t_exp_reg    <= 2'd0;
      sync_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      t_exp_reg    <= t_exp_next;
      sync_err_reg <= sync_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    t_exp_next    = t_exp_reg;
    sync_err_next = sync_err_reg;
    case (state_reg)
      HALT: begin
        if (run) state_next = START;
      end
      START: begin
        // The counter sees E fall on this edge and restarts at T=0
        state_next = RUN;
        phase_next = PH_FETCH;
        t_exp_next = 2'd0;
      end
      RUN: begin
        // A lost step outranks HLT: the opcode cannot be trusted off-sync
        if (!t_match) begin
          state_next    = RESYNC;
          sync_err_next = 1'b1;
          phase_next    = PH_FETCH;
          t_exp_next    = 2'd0;
        end else if (hlt_dec) begin
          state_next = HALT;
          phase_next = PH_FETCH;
          t_exp_next = 2'd0;
        end else begin
          t_exp_next = t_exp_reg + 2'd1;
          if (t_exp_reg == 2'd3) phase_next = ~phase_reg;
        end
      end
      RESYNC: begin
        state_next = START;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  always_comb begin
    sc_e    = 1'b1;
    halted  = 1'b0;
    uop_out = '0;
    case (state_reg)
      HALT:   halted = 1'b1;
      START:  sc_e = 1'b0;
      RUN: begin
        sc_e = 1'b0;
        // Reset wins in its own cycle so an aborted instruction writes nothing
        if (t_match && rst) uop_out = uop_dec;
      end
      RESYNC: sc_e = 1'b1;
      default: halted = 1'b1;
    endcase
  end

  assign phase     = phase_reg;
  assign sync_err  = sync_err_reg;
  assign ar_ld_pc  = uop_out.ar_ld_pc;
  assign ar_ld_ir  = uop_out.ar_ld_ir;
  assign ar_ld_mem = uop_out.ar_ld_mem;
  assign ir_ld     = uop_out.ir_ld;
  assign pc_inc    = uop_out.pc_inc;
  assign pc_ld_ar  = uop_out.pc_ld_ar;
  assign mem_rd    = uop_out.mem_rd;
  assign mem_wr    = uop_out.mem_wr;
  assign dr_ld     = uop_out.dr_ld;
  assign ac_ld     = uop_out.ac_ld;
  assign alu_op    = uop_out.alu_op;

endmodule
